collision_ctrl: RTL and testbench
=================================

Name: collision_ctrl

Overview:
- Game-state and collision controller directly downstream of the character sprite stage.
- Consumes the character's per-pixel visibility together with the obstacle layer's per-pixel visibility, and counts overlapping pixels each frame.
- Produces the `hit` freeze signal that feeds back into the character and obstacle stages.
- Also owns the run score and the idle/run/hit/game-over state machine driven by the start key.

Parameters:
- OVERLAP_MIN, 8'd16: minimum overlapping pixels in one frame that counts as a collision (1..255).
- HOLD_FRAMES, 8'd60: frames spent in HIT before entering OVER; start_key is ignored during these frames.
- SCORE_DIV, 6'd6: RUN frames per score increment.

Ports:
- clock  input  1  pixel clock, shared with the sprite stages.
- reset  input  1  asynchronous, active-low reset (asserted while 0).
- display_col  input  12  current pixel column.
- display_row  input  11  current pixel row.
- visible  input  1  active video region.
- char_visible  input  1  character sprite pixel opaque (registered output of the character stage).
- obst_visible  input  1  obstacle pixel opaque (same pipeline alignment as char_visible).
- start_key  input  1  asynchronous push button, active-high.
- hit  output  1  freeze request to the sprite stages; 1 in IDLE, HIT and OVER, 0 in RUN.
- game_over  output  1  1 only in OVER.
- collide_pulse  output  1  one-clock pulse when a collision frame is accepted.
- score  output  16  frames-survived score, binary.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, hit=1, game_over=0, collide_pulse=0, score=0.
  - Overlap counter, frame-divider counter, hold counter and key synchroniser all cleared.
- Frame start:
  - frame_start = rising edge of (display_col==0 && display_row==0), detected against a registered copy of that condition.
  - It is exactly one clock per frame even when the condition holds for several clocks.
- start_key handling:
  - Passed through a 2-flop synchroniser, then rising-edge detected giving key_rise, one clock wide.
  - Level-held keys produce a single key_rise.
- Overlap counter (8-bit):
  - Increments on every clock where visible && char_visible && obst_visible.
  - Saturates at 255.
  - On frame_start it is evaluated (collision = count >= OVERLAP_MIN), then cleared to 0 in that same clock.
  - A pixel coinciding with frame_start is not counted.
- State machine (transitions take effect on the clock edge):
  - IDLE: hit=1. key_rise goes to RUN; score, divider and overlap counters are cleared on entry.
  - RUN: hit=0.
    - On frame_start with collision: go to HIT, collide_pulse=1 for that clock, hold counter cleared.
    - On frame_start without collision: divider increments; when the divider reaches SCORE_DIV-1 it wraps to 0 and score increments.
    - Collision and score tick on the same frame_start: collision wins and score is not incremented.
  - HIT: hit=1, score frozen. Hold counter increments on each frame_start; when it reaches HOLD_FRAMES-1 at a frame_start, go to OVER. key_rise is ignored.
  - OVER: hit=1, game_over=1, score held. key_rise goes to RUN; score, divider and overlap counters are cleared.
- score saturates at 16'hFFFF and never wraps.
- Latency:
  - collide_pulse, hit and game_over are registered.
  - hit rises one clock after the frame_start that evaluated the collision.
- Reset mid-operation: any state returns immediately to IDLE with the reset values above; no partial-frame collision survives reset.
- Overlap accumulates in every state but only RUN acts on it.

Test Plan:
- Reset then idle: reset=0 for 5 clocks, release, run 3 frames with no key → hit=1, game_over=0, score=0, state stays IDLE.
- Start and score: one start_key pulse (held 1000 clocks), 12 frames with no overlap → single transition to RUN, hit=0, score=2 (SCORE_DIV=6); no second start from the held key.
- Collision threshold: in RUN, frame with 15 overlapping pixels → no hit. Next frame with 16 overlapping pixels → at the next frame_start collide_pulse=1 for one clock, hit=1 the following clock, score frozen.
- Hold and game over: after the collision, press start_key at hold frame 10 → ignored. After 60 frame_starts → game_over=1. Press start_key → RUN, score=0, game_over=0, hit=0.
- Simultaneous events: arrange a collision frame whose frame_start is also the 6th divider frame → score unchanged, state HIT.
- Reset mid-run: assert reset in RUN with score=37 partway through a frame → outputs immediately hit=1, score=0, collide_pulse=0; after release, state is IDLE.

Source files
------------

// File: rtl/collision_ctrl_if.sv
// Pixel-side bundle between the sprite pipeline and the collision controller.
// master drives the raster/visibility/key signals; slave is the controller.
interface collision_ctrl_if;
    localparam int unsigned COL_W   = 12;
    localparam int unsigned ROW_W   = 11;
    localparam int unsigned SCORE_W = 16;

    logic [COL_W-1:0]   display_col;
    logic [ROW_W-1:0]   display_row;
    logic               visible;
    logic               char_visible;
    logic               obst_visible;
    logic               start_key;
    logic               hit;
    logic               game_over;
    logic               collide_pulse;
    logic [SCORE_W-1:0] score;

    modport master (
        output display_col, display_row, visible, char_visible, obst_visible, start_key,
        input  hit, game_over, collide_pulse, score
    );

    modport slave (
        input  display_col, display_row, visible, char_visible, obst_visible, start_key,
        output hit, game_over, collide_pulse, score
    );
endinterface

// File: rtl/collision_ctrl.sv
// Game-state and collision controller: per-frame character/obstacle overlap
// counting, idle/run/hit/over sequencing, hit freeze request and run score.
module collision_ctrl #(
    parameter logic [7:0] OVERLAP_MIN = 8'd16,
    parameter logic [7:0] HOLD_FRAMES = 8'd60,
    parameter logic [5:0] SCORE_DIV   = 6'd6
) (
    input logic           clock,
    input logic           reset,
    collision_ctrl_if.slave bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DIV_W   = 6;
    localparam int unsigned SCORE_W = 16;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HIT,
        ST_OVER
    } state_t;

    state_t             state;
    logic               origin_c;
    logic               origin_q;
    logic               frame_start_c;
    logic [2:0]         key_sync;
    logic               key_rise_c;
    logic               overlap_px_c;
    logic               collision_c;
    logic               run_entry_c;
    logic [CNT_W-1:0]   overlap_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   hold_cnt;
    logic               hit_q;
    logic               game_over_q;
    logic               collide_q;
    logic [SCORE_W-1:0] score_q;

    assign origin_c      = (bus.display_col == '0) && (bus.display_row == '0);
    assign frame_start_c = origin_c && !origin_q;
    assign key_rise_c    = key_sync[1] && !key_sync[2];
    assign overlap_px_c  = bus.visible && bus.char_visible && bus.obst_visible;
    assign collision_c   = overlap_cnt >= OVERLAP_MIN;
    assign run_entry_c   = key_rise_c && ((state == ST_IDLE) || (state == ST_OVER));

    // Frame-origin edge detector and key synchroniser (bits 0,1 sync, bit 2 edge history)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            origin_q <= 1'b0;
            key_sync <= 3'b000;
        end else begin
            origin_q <= origin_c;
            key_sync <= {key_sync[1:0], bus.start_key};
        end
    end

    // Overlap accumulates in every state; frame start samples it and restarts the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overlap_cnt <= '0;
        end else if (run_entry_c || frame_start_c) begin
            overlap_cnt <= '0;
        end else if (overlap_px_c && (overlap_cnt != CNT_MAX)) begin
            overlap_cnt <= overlap_cnt + CNT_W'(1);
        end
    end

    // Game sequencing with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            div_cnt     <= '0;
            hold_cnt    <= '0;
            hit_q       <= 1'b1;
            game_over_q <= 1'b0;
            collide_q   <= 1'b0;
            score_q     <= '0;
        end else begin
            collide_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (key_rise_c) begin
                        state       <= ST_RUN;
                        hit_q       <= 1'b0;
                        game_over_q <= 1'b0;
                        score_q     <= '0;
                        div_cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_start_c) begin
                        if (collision_c) begin
                            state     <= ST_HIT;
                            hit_q     <= 1'b1;
                            collide_q <= 1'b1;
                            hold_cnt  <= '0;
                        end else if (div_cnt == (SCORE_DIV - DIV_W'(1))) begin
                            div_cnt <= '0;
                            if (score_q != SCORE_MAX) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                ST_HIT: begin
                    if (frame_start_c) begin
                        if (hold_cnt == (HOLD_FRAMES - CNT_W'(1))) begin
                            state       <= ST_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    hit_q       <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hit           = hit_q;
    assign bus.game_over     = game_over_q;
    assign bus.collide_pulse = collide_q;
    assign bus.score         = score_q;
endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: small 20x2 raster, frame-level reference
// model checked every cycle, plus literal checkpoints along the game sequence.
module tb_collision_ctrl;
    localparam int FRAME_W  = 20;
    localparam int FRAME_H  = 2;
    localparam int OVL_MIN  = 16;
    localparam int HOLD_N   = 60;
    localparam int DIV_N    = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_pulse = 0;

    collision_ctrl_if bus ();

    collision_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: game rules expressed as frame/event counts
    typedef enum {M_IDLE, M_RUN, M_HIT, M_OVER} mstate_t;
    mstate_t  m_st;
    int       m_ov, m_runf, m_holdf, m_score;
    bit       m_prev, m_pulse;
    bit [3:0] m_kh;

    always @(posedge clock or negedge reset) begin : model
        bit origin, fs, rise, coll, pix, enter, pulse_n;
        int ov_n, sc_n, runf_n, holdf_n;
        mstate_t st_n;
        if (!reset) begin
            m_st <= M_IDLE; m_ov <= 0; m_runf <= 0; m_holdf <= 0; m_score <= 0;
            m_prev <= 1'b0; m_pulse <= 1'b0; m_kh <= 4'b0;
        end else begin
            origin  = (bus.display_col == 12'd0) && (bus.display_row == 11'd0);
            fs      = origin && !m_prev;
            rise    = m_kh[1] && !m_kh[2];
            coll    = fs && (m_ov >= OVL_MIN);
            pix     = bus.visible && bus.char_visible && bus.obst_visible;
            st_n    = m_st; sc_n = m_score; runf_n = m_runf; holdf_n = m_holdf;
            pulse_n = 1'b0; enter = 1'b0;
            case (m_st)
                M_IDLE, M_OVER: if (rise) begin st_n = M_RUN; sc_n = 0; runf_n = 0; enter = 1'b1; end
                M_RUN: begin
                    if (coll) begin
                        st_n = M_HIT; pulse_n = 1'b1; holdf_n = 0;
                    end else if (fs) begin
                        runf_n = m_runf + 1;
                        if ((runf_n % DIV_N) == 0 && sc_n < 65535) sc_n = sc_n + 1;
                    end
                end
                M_HIT: if (fs) begin
                    holdf_n = m_holdf + 1;
                    if (holdf_n == HOLD_N) st_n = M_OVER;
                end
                default: st_n = M_IDLE;
            endcase
            if (enter || fs)   ov_n = 0;
            else if (pix)      ov_n = (m_ov < 255) ? m_ov + 1 : 255;
            else               ov_n = m_ov;
            m_st <= st_n; m_score <= sc_n; m_runf <= runf_n; m_holdf <= holdf_n;
            m_pulse <= pulse_n; m_ov <= ov_n; m_prev <= origin;
            m_kh <= {m_kh[2:0], bus.start_key};
        end
    end

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, taken on the falling edge
    task automatic cmp_model();
        cmp("hit",       16'(bus.hit),           16'(m_st != M_RUN));
        cmp("game_over", 16'(bus.game_over),     16'(m_st == M_OVER));
        cmp("pulse",     16'(bus.collide_pulse), 16'(m_pulse));
        cmp("score",     bus.score,              16'(m_score));
        if (bus.collide_pulse === 1'b1) n_pulse++;
    endtask

    // One pixel: check outputs, then drive the next raster position
    task automatic px(input int col, input int row, input int n);
        @(negedge clock);
        cmp_model();
        bus.display_col  = 12'(col);
        bus.display_row  = 11'(row);
        bus.visible      = (col >= 1) && (col <= 18);
        bus.char_visible = ((row == 0) && (col >= 1) && (col <= n)) || (row == 1);
        bus.obst_visible = ((row == 0) && (col >= 1) && (col <= n)) || ((row == 1) && (col >= 19));
    endtask

    task automatic frame_tail(input int n);
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < FRAME_W; c++)
                if (!(r == 0 && c == 0)) px(c, r, n);
    endtask

    task automatic frame(input int n, input int stall);
        repeat (stall + 1) px(0, 0, n);
        frame_tail(n);
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic h, input logic g, input logic p, input int s);
        cmp({tag, ".hit"},       16'(bus.hit),           16'(h));
        cmp({tag, ".game_over"}, 16'(bus.game_over),     16'(g));
        cmp({tag, ".pulse"},     16'(bus.collide_pulse), 16'(p));
        cmp({tag, ".score"},     bus.score,              16'(s));
    endtask

    initial begin
        bus.display_col = 12'd5; bus.display_row = 11'd1;
        bus.visible = 1'b0; bus.char_visible = 1'b0; bus.obst_visible = 1'b0;
        bus.start_key = 1'b0;

        // Reset held for 5 clocks, then idle frames with no key
        repeat (5) px(5, 1, 0);
        chk_out("reset", 1'b1, 1'b0, 1'b0, 0);
        reset = 1'b1;
        repeat (3) frame(0, 0);
        settle();
        chk_out("idle", 1'b1, 1'b0, 1'b0, 0);

        // Start key held ~1000 clocks; origin stalled 3 clocks in frame 2
        bus.start_key = 1'b1;
        frame(0, 0);
        frame(0, 2);
        repeat (11) frame(0, 0);
        settle();
        chk_out("run12", 1'b0, 1'b0, 1'b0, 2);
        repeat (12) frame(0, 0);
        settle();
        chk_out("run24", 1'b0, 1'b0, 1'b0, 4);
        bus.start_key = 1'b0;

        // Threshold: 15 overlaps no hit, 16 overlaps hit at next frame start
        frame(15, 0);
        frame(16, 0);
        settle();
        chk_out("below", 1'b0, 1'b0, 1'b0, 4);
        px(0, 0, 0);
        settle();
        chk_out("collide", 1'b1, 1'b0, 1'b1, 4);
        frame_tail(0);
        settle();
        chk_out("hit_hold", 1'b1, 1'b0, 1'b0, 4);
        cmp("pulse_count", 16'(n_pulse), 16'd1);

        // Hold: key at hold frame 10 ignored, OVER on the 60th frame start
        repeat (9) frame(0, 0);
        bus.start_key = 1'b1;
        frame(0, 0);
        bus.start_key = 1'b0;
        repeat (49) frame(0, 0);
        settle();
        chk_out("hold59", 1'b1, 1'b0, 1'b0, 4);
        frame(0, 0);
        settle();
        chk_out("over", 1'b1, 1'b1, 1'b0, 4);
        bus.start_key = 1'b1;
        frame(0, 0);
        settle();
        chk_out("restart", 1'b0, 1'b0, 1'b0, 0);
        bus.start_key = 1'b0;

        // Collision on the 6th divider frame start: collision wins, no score
        repeat (4) frame(0, 0);
        frame(16, 0);
        px(0, 0, 0);
        settle();
        chk_out("simul", 1'b1, 1'b0, 1'b1, 0);
        for (int c = 1; c < 8; c++) px(c, 0, 0);
        #2 reset = 1'b0;
        #1 chk_out("rst_hit", 1'b1, 1'b0, 1'b0, 0);
        px(8, 0, 0);
        reset = 1'b1;

        // Build score 37 from idle, then reset mid-frame
        bus.start_key = 1'b1;
        frame(0, 0);
        bus.start_key = 1'b0;
        for (int i = 0; i < 222; i++) frame(((i % 3) == 0) ? 15 : 0, 0);
        for (int c = 0; c < 12; c++) px(c, 0, 18);
        settle();
        chk_out("score37", 1'b0, 1'b0, 1'b0, 37);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 chk_out("rst_run", 1'b1, 1'b0, 1'b0, 0);
        px(12, 0, 18);
        px(13, 0, 18);
        reset = 1'b1;
        frame(0, 0);
        frame(0, 0);
        settle();
        chk_out("post_rst", 1'b1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
